// File: rtl/life_gen_engine.sv
`default_nettype none
// ============================================================================
// Module   : life_gen_engine
// Brief    : Computes one Game of Life generation in place over a bank of
//            HEIGHT row registers, one row per clock, buffering the original
//            neighbour rows that have already been overwritten.
// Revision : 1.0 - initial release
// ============================================================================
module life_gen_engine #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int WRAP   = 1,
  parameter int GEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  output logic [$clog2(HEIGHT)-1:0] rd_addr_o,
  input  logic [WIDTH-1:0]          rd_row_i,
  output logic                      wr_en_o,
  output logic [$clog2(HEIGHT)-1:0] wr_addr_o,
  output logic [WIDTH-1:0]          wr_row_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [GEN_W-1:0]          gen_count_o
);

  localparam int AW = $clog2(HEIGHT);
  localparam logic [AW-1:0] c_last_row = AW'(HEIGHT - 1);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_prime_top = 3'd1;
  localparam logic [2:0] c_st_prime_cur = 3'd2;
  localparam logic [2:0] c_st_step      = 3'd3;
  localparam logic [2:0] c_st_finish    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] above_q, above_d;   // original row r-1
  logic [WIDTH-1:0] cur_q,   cur_d;     // original row r
  logic [WIDTH-1:0] first_q, first_d;   // original row 0, needed as "below" of the last row
  logic [AW-1:0]    row_q,   row_d;
  logic [GEN_W-1:0] gen_q,   gen_d;

  logic             w_last;
  logic [WIDTH-1:0] w_below;
  logic [WIDTH-1:0] w_next;

  assign w_last  = (row_q == c_last_row);
  // Row 0 has been overwritten by the time the last row is processed.
  assign w_below = w_last ? ((WRAP != 0) ? first_q : '0) : rd_row_i;

  // Per-column neighbour count and life rule.
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int c_l     = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int c_r     = (c == WIDTH - 1) ? 0 : c + 1;
    localparam bit c_has_l = (WRAP != 0) || (c != 0);
    localparam bit c_has_r = (WRAP != 0) || (c != WIDTH - 1);

    logic       w_al, w_ar, w_cl, w_cr, w_bl, w_br;
    logic [3:0] w_n;

    assign w_al = c_has_l & above_q[c_l];
    assign w_ar = c_has_r & above_q[c_r];
    assign w_cl = c_has_l & cur_q[c_l];
    assign w_cr = c_has_r & cur_q[c_r];
    assign w_bl = c_has_l & w_below[c_l];
    assign w_br = c_has_r & w_below[c_r];

    assign w_n = 4'(w_al) + 4'(above_q[c]) + 4'(w_ar)
               + 4'(w_cl) + 4'(w_cr)
               + 4'(w_bl) + 4'(w_below[c]) + 4'(w_br);

    assign w_next[c] = (w_n == 4'd3) | (cur_q[c] & (w_n == 4'd2));
  end

  // Next-state logic for the sequencer and the row buffers.
  always_comb begin
    state_d = state_q;
    above_d = above_q;
    cur_d   = cur_q;
    first_d = first_q;
    row_d   = row_q;
    gen_d   = gen_q;
    case (state_q)
      c_st_idle: begin
        if (start_i) state_d = c_st_prime_top;
      end
      c_st_prime_top: begin
        above_d = (WRAP != 0) ? rd_row_i : '0;
        state_d = c_st_prime_cur;
      end
      c_st_prime_cur: begin
        cur_d   = rd_row_i;
        first_d = rd_row_i;
        row_d   = '0;
        state_d = c_st_step;
      end
      c_st_step: begin
        above_d = cur_q;
        cur_d   = w_below;
        if (w_last) begin
          row_d   = '0;
          state_d = c_st_finish;
        end else begin
          row_d   = row_q + 1'b1;
        end
      end
      c_st_finish: begin
        gen_d   = gen_q + 1'b1;
        state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // State and buffer registers; reset abandons any generation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_st_idle;
      above_q <= '0;
      cur_q   <= '0;
      first_q <= '0;
      row_q   <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      above_q <= above_d;
      cur_q   <= cur_d;
      first_q <= first_d;
      row_q   <= row_d;
      gen_q   <= gen_d;
    end
  end

  // Bank read address and write port, decoded from the current state.
  always_comb begin
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_row_o  = '0;
    case (state_q)
      c_st_prime_top: rd_addr_o = c_last_row;
      c_st_step: begin
        rd_addr_o = w_last ? '0 : row_q + 1'b1;
        wr_en_o   = 1'b1;
        wr_addr_o = row_q;
        wr_row_o  = w_next;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state_q != c_st_idle);
  assign done_o      = (state_q == c_st_finish);
  assign gen_count_o = gen_q;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_gen_engine
// Brief    : Directed self-checking bench for life_gen_engine. One instance
//            uses toroidal edges, the other dead edges with a 2-bit counter;
//            both share a bench-owned row register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_gen_engine;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_w = 1'b0;
  logic start_d = 1'b0;
  logic use_d = 1'b0;
  logic load = 1'b0;

  logic [W-1:0] grid      [H];
  logic [W-1:0] init_grid [H];

  logic [2:0]   w_rd_addr, w_wr_addr, d_rd_addr, d_wr_addr;
  logic [W-1:0] w_rd_row, w_wr_row, d_rd_row, d_wr_row;
  logic         w_wr_en, w_busy, w_done, d_wr_en, d_busy, d_done;
  logic [15:0]  w_gen;
  logic [1:0]   d_gen;

  logic         m_wr_en, m_busy, m_done;
  logic [2:0]   m_wr_addr;
  logic [15:0]  m_gen;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  life_gen_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1), .GEN_W(16)) dut_w (
    .clk(clk), .reset(reset), .start_i(start_w),
    .rd_addr_o(w_rd_addr), .rd_row_i(w_rd_row),
    .wr_en_o(w_wr_en), .wr_addr_o(w_wr_addr), .wr_row_o(w_wr_row),
    .busy_o(w_busy), .done_o(w_done), .gen_count_o(w_gen)
  );

  life_gen_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0), .GEN_W(2)) dut_d (
    .clk(clk), .reset(reset), .start_i(start_d),
    .rd_addr_o(d_rd_addr), .rd_row_i(d_rd_row),
    .wr_en_o(d_wr_en), .wr_addr_o(d_wr_addr), .wr_row_o(d_wr_row),
    .busy_o(d_busy), .done_o(d_done), .gen_count_o(d_gen)
  );

  // Row register bank: bulk load from the bench, otherwise one row write per clock.
  always @(posedge clk) begin
    if (load) grid <= init_grid;
    else if (w_wr_en) grid[w_wr_addr] <= w_wr_row;
    else if (d_wr_en) grid[d_wr_addr] <= d_wr_row;
  end

  assign w_rd_row = grid[w_rd_addr];
  assign d_rd_row = grid[d_rd_addr];

  assign m_wr_en   = use_d ? d_wr_en   : w_wr_en;
  assign m_wr_addr = use_d ? d_wr_addr : w_wr_addr;
  assign m_busy    = use_d ? d_busy    : w_busy;
  assign m_done    = use_d ? d_done    : w_done;
  assign m_gen     = use_d ? {14'd0, d_gen} : w_gen;

  task automatic load_grid(input logic [W-1:0] g [H]);
    @(posedge clk); #1;
    init_grid = g;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_grid(input string name, input logic [W-1:0] exp_g [H]);
    for (int r = 0; r < H; r++) begin
      vectors++;
      if (grid[r] !== exp_g[r]) begin
        miscompares++;
        $display("FAIL %s row%0d: got %h expected %h", name, r, grid[r], exp_g[r]);
      end
    end
  endtask

  task automatic check_gen(input string name, input logic [15:0] exp_v);
    vectors++;
    if (m_gen !== exp_v) begin
      miscompares++;
      $display("FAIL %s gen_count: got %0d expected %0d", name, m_gen, exp_v);
    end
  endtask

  // One generation on the selected instance with cycle-accurate output checks.
  task automatic run_gen(input string name);
    logic exp_en;
    @(posedge clk); #1;
    if (use_d) start_d = 1'b1; else start_w = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    start_w = 1'b0;
    for (int k = 1; k <= H + 4; k++) begin
      exp_en = (k >= 3) && (k <= H + 2);
      vectors++;
      if (m_wr_en !== exp_en) begin
        miscompares++;
        $display("FAIL %s wr_en cycle %0d: got %b expected %b", name, k, m_wr_en, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (m_wr_addr !== 3'(k - 3)) begin
          miscompares++;
          $display("FAIL %s wr_addr cycle %0d: got %0d expected %0d", name, k, m_wr_addr, k - 3);
        end
      end
      vectors++;
      if (m_done !== (k == H + 3)) begin
        miscompares++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, k, m_done, (k == H + 3));
      end
      vectors++;
      if (m_busy !== (k <= H + 3)) begin
        miscompares++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, m_busy, (k <= H + 3));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({w_wr_en, w_busy, w_done, d_wr_en, d_busy, d_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset flags: got %b expected 000000",
               {w_wr_en, w_busy, w_done, d_wr_en, d_busy, d_done});
    end
    vectors++;
    if ({w_rd_addr, w_wr_addr, w_wr_row, w_gen} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset wrap outputs: got %h expected 0", {w_rd_addr, w_wr_addr, w_wr_row, w_gen});
    end
    vectors++;
    if ({d_rd_addr, d_wr_addr, d_wr_row, d_gen} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset dead outputs: got %h expected 0", {d_rd_addr, d_wr_addr, d_wr_row, d_gen});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_blinker();
    logic [W-1:0] g [H];
    use_d = 1'b0;
    g = '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    load_grid(g);
    run_gen("blinker1");
    check_grid("blinker1", '{8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00});
    check_gen("blinker1", 16'd1);
    run_gen("blinker2");
    check_grid("blinker2", g);
    check_gen("blinker2", 16'd2);
  endtask

  task automatic test_block_wrap();
    logic [W-1:0] g [H];
    g = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
    use_d = 1'b0;
    load_grid(g);
    run_gen("block_wrap");
    check_grid("block_wrap", g);
    use_d = 1'b1;
    load_grid(g);
    run_gen("block_nowrap");
    check_grid("block_nowrap", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    use_d = 1'b0;
  endtask

  task automatic test_dead_border();
    logic [W-1:0] g [H];
    use_d = 1'b1;
    g = '{8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_grid(g);
    run_gen("border_block");
    check_grid("border_block", g);
    g = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_grid(g);
    run_gen("border_single");
    check_grid("border_single", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    use_d = 1'b0;
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] g [H];
    int done_cnt;
    use_d = 1'b0;
    g = '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_reset();
    load_grid(g);
    done_cnt = 0;
    @(posedge clk); #1;
    start_w = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (k == 20) start_w = 1'b0;
      if (w_done) done_cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cnt != 2) begin
      miscompares++;
      $display("FAIL busy_start done pulses: got %0d expected 2", done_cnt);
    end
    check_gen("busy_start", 16'd2);
    check_grid("busy_start", g);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] g [H];
    use_d = 1'b0;
    g = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    load_grid(g);
    @(posedge clk); #1;
    start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({w_wr_en, w_busy, w_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset flags: got %b expected 000", {w_wr_en, w_busy, w_done});
    end
    check_gen("midreset", 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_grid("midreset", '{8'h83, 8'h83, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01});
    g = '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    load_grid(g);
    run_gen("after_reset");
    check_grid("after_reset", '{8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00});
    check_gen("after_reset", 16'd1);
  endtask

  task automatic test_counter_wrap();
    logic [W-1:0] g [H];
    logic [15:0] exp_seq [4];
    use_d = 1'b1;
    exp_seq = '{16'd1, 16'd2, 16'd3, 16'd0};
    g = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_reset();
    load_grid(g);
    for (int i = 0; i < 4; i++) begin
      run_gen("counter");
      check_gen("counter", exp_seq[i]);
    end
    use_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block_wrap();
    test_dead_border();
    test_start_while_busy();
    test_reset_mid_run();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
- Computes one Game of Life generation over a HEIGHT x WIDTH grid held in the team's bank of per-row DFF registers (register width WIDTH, write-enable, async reset).
- Sits directly upstream of that bank: reads current rows through a combinational read port, and drives the row registers' d/we inputs.
- Updates the grid in place, one row per clock, and buffers the original rows it still needs.

Parameters:
- WIDTH, 8, cells per row (>=3); bit c of a row is column c.
- HEIGHT, 8, number of rows (>=3).
- WRAP, 1, 1 = toroidal edges (rows and columns); 0 = cells outside the grid are dead.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the block to IDLE.
- start  input  1  request one generation; sampled only in IDLE.
- rd_addr  output  $clog2(HEIGHT)  row index presented to the bank's read mux.
- rd_row  input  WIDTH  current (pre-edge) contents of row rd_addr, combinational from the bank.
- wr_en  output  1  write enable to the row register selected by wr_addr.
- wr_addr  output  $clog2(HEIGHT)  row being written.
- wr_row  output  WIDTH  next-generation value of row wr_addr.
- busy  output  1  high from the first cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a generation completes.
- gen_count  output  GEN_W  number of completed generations; wraps modulo 2^GEN_W.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- While reset is high:
  - state = IDLE.
  - wr_en, busy, done = 0; wr_addr, wr_row, rd_addr = 0; gen_count = 0.
  - All row buffers = 0.
- States: IDLE -> PRIME_TOP -> PRIME_CUR -> STEP (HEIGHT cycles) -> FINISH -> IDLE.
- IDLE:
  - rd_addr = 0, wr_en = 0.
  - start=1 at an edge moves to PRIME_TOP.
  - start is ignored in every other state; there is no queueing.
- PRIME_TOP (1 cycle):
  - rd_addr = HEIGHT-1.
  - above_buf <= rd_row if WRAP, else 0.
- PRIME_CUR (1 cycle):
  - rd_addr = 0.
  - cur_buf <= rd_row and first_buf <= rd_row.
  - row counter r <= 0.
- STEP, row r, one cycle each:
  - below = rd_row with rd_addr = r+1 for r < HEIGHT-1.
  - For r = HEIGHT-1: below = first_buf if WRAP, else 0; rd_addr = 0 (don't-care).
  - wr_en = 1, wr_addr = r, wr_row = next(above_buf, cur_buf, below). These outputs are combinational from state and buffers, valid in the same cycle.
  - At the edge: above_buf <= cur_buf, cur_buf <= below, r <= r+1.
  - After r = HEIGHT-1, go to FINISH.
- FINISH (1 cycle):
  - done = 1, wr_en = 0, gen_count <= gen_count+1.
  - Next state IDLE.
- Rule per cell:
  - n = sum of 8 neighbours, a 4-bit value in 0..8.
  - New cell = (n==3) | (alive & n==2).
  - Column neighbours wrap (c-1 of column 0 = WIDTH-1) when WRAP=1; they are 0 otherwise.
- In-place safety:
  - Row r is written at the end of the cycle that reads row r+1.
  - Original row r-1 comes from above_buf and original row 0 from first_buf, so no overwritten row is ever re-read.
- busy = 1 in PRIME_TOP, PRIME_CUR, STEP and FINISH. done and busy both assert in FINISH.
- Latency: start sampled at edge of cycle 0; rows written in cycles 3..HEIGHT+2; done in cycle HEIGHT+3. Back-to-back start is possible from cycle HEIGHT+4.
- Reset mid-operation:
  - Immediate IDLE; the write in progress is not performed.
  - The grid is left partially updated; no recovery is attempted.

Test Plan:
- Blinker (8x8, WRAP=1): row3 = 8'h1C, other rows 0; pulse start -> wr_en high cycles 3..10, rows 2,3,4 = 8'h08, all others 0. done in cycle 11, gen_count = 1. Second run restores row3 = 8'h1C, gen_count = 2.
- Block across wrap (WRAP=1): cells (7,7),(7,0),(0,7),(0,0), i.e. row0 = row7 = 8'h81 -> unchanged after one generation. With WRAP=0 the same pattern gives all rows 0.
- Dead border (WRAP=0): 2x2 block at rows 0-1, cols 0-1 (8'h03) -> unchanged. A single cell at row0 = 8'h01 -> all rows 0.
- Start while busy: start held high for 20 cycles from idle -> exactly two generations (second accepted the cycle after FINISH); gen_count = 2; done pulses once per generation.
- Reset mid-run: assert reset in cycle 5 -> wr_en, busy, done, gen_count read 0 in the same cycle. Rows 0-1 are already written; rows 2-7 are unchanged. A new start then runs normally.
- Counter wrap (GEN_W=2): four generations -> gen_count sequence 1, 2, 3, 0.
